writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  WB pipeline stage, directly downstream of the MEM stage; consumes its MEMWB registers.
//  - Aligns, masks and sign-extends load data.
//  - Selects the register write value, suppresses writes to x0, and registers the result
//    into the WBID write port of the ID-stage register file.
//  - Provides a same-cycle forward tap and a retired-instruction counter.
// PARAMETERS
//  WIDTH        32  data word width in bits
//  CNT_WIDTH    64  width of retired-instruction counter
// PORTS
//  clk                 in   1         rising-edge clock
//  reset               in   1         asynchronous, active-low reset
//  instr_valid_MEMWB   in   1         MEMWB holds a real (non-bubble) instruction
//  ALU_out_MEMWB       in   WIDTH     ALU result / load address
//  pc_4_MEMWB          in   WIDTH     PC+4 of the instruction
//  mem_rd_data_MEMWB   in   WIDTH     raw 32-bit word read from data memory
//  reg_wr_ctrl_MEMWB   in   2         write source select: 0 ALU, 1 PC+4, 2 MEM, 3 reserved
//  funct3_MEMWB        in   3         load type
//  byte_offset_MEMWB   in   2         load address [1:0]
//  rd_MEMWB            in   5         destination register
//  reg_wr_en_MEMWB     in   1         destination write requested
//  wb_fwd_data         out  WIDTH     combinational write value, for EX forwarding
//  wb_fwd_en           out  1         combinational: reg_wr_en_MEMWB & rd_MEMWB!=0 & instr_valid_MEMWB
//  reg_wr_data_WBID    out  WIDTH     registered register-file write data
//  rd_WBID             out  5         registered register-file write address
//  reg_wr_en_WBID      out  1         registered register-file write enable
//  instret             out  CNT_WIDTH retired-instruction count
//  misalign_clr        in   1         clear sticky misalign flag (WB_MISALIGN_TRAP_EN only)
//  misalign_err        out  1         sticky misaligned-load flag
//  misalign_addr       out  WIDTH     address of first misaligned load
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): every registered output = 0, including instret,
//    misalign_err and misalign_addr.
//  - Load align, combinational. shifted = mem_rd_data_MEMWB >> (8*byte_offset).
//      LB  (000): sign-extend shifted[7:0]
//      LH  (001): sign-extend shifted[15:0]
//      LW  (010): raw word
//      LBU (100): zero-extend shifted[7:0]
//      LHU (101): zero-extend shifted[15:0]
//      other funct3: raw word
//    For LH/LHU with offset 3, the upper bytes shift in as 0; no wrap-around.
//  - Write value select: reg_wr_ctrl 0 -> ALU_out, 1 -> pc_4, 2 -> aligned load, 3 -> 32'h0.
//  - Latency: MEMWB inputs appear on the WBID outputs 1 cycle later, every cycle, with no stall.
//  - Write-enable gating: reg_wr_en_WBID = reg_wr_en_MEMWB & instr_valid_MEMWB & (rd_MEMWB!=0).
//    rd_WBID and reg_wr_data_WBID are registered unconditionally.
//  - instret: +1 on each cycle with instr_valid_MEMWB=1; wraps from all-ones to 0 with no flag.
//  - Reset mid-stream: the in-flight WBID write is dropped (enable returns to 0).
// CONFIGURATION
//  Macro: WB_MISALIGN_TRAP_EN.
//  - Defined: a misaligned load is instr_valid & reg_wr_ctrl==2 & one of:
//      (LH|LHU) & byte_offset[0]==1
//      LW & byte_offset!=0
//    On the first such load while misalign_err==0:
//      misalign_err <= 1, misalign_addr <= ALU_out_MEMWB.
//    Later events do not overwrite misalign_addr.
//    misalign_clr clears the flag; when set and clear occur in the same cycle, set wins
//    and the new address is captured. Load data is still produced per the align rules.
//  - Undefined: misalign_err and misalign_addr are tied to 0, misalign_clr is ignored,
//    and no flops are inferred.
// STRUCTURE
//  - wb_pkg: typedef enum logic[1:0] wb_src_e {WB_ALU, WB_PC4, WB_MEM, WB_RSVD};
//    load funct3 constants (the existing inst_defs.sv load defines are reused there).
//  - Sub-module load_align: combinational shifter/extender,
//    inputs (word, offset, funct3) -> data.
//  - Top level holds the mux, the WBID flops, instret and the misalign logic.
// TESTING
//  1. LB, mem=32'h80FF_7F01, off=3 -> reg_wr_data_WBID=32'hFFFF_FF80 one cycle later;
//     LBU, same word and offset -> 32'h0000_0080.
//  2. LH, mem=32'h8001_1234, off=2 -> 32'hFFFF_8001; LHU -> 32'h0000_8001;
//     LW, off=0 -> raw word.
//  3. reg_wr_ctrl=1, pc_4=32'h104, rd=5 -> data=32'h104, rd_WBID=5, en=1;
//     same with rd=0 -> reg_wr_en_WBID=0, wb_fwd_en=0.
//  4. 10 valid + 3 bubble cycles -> instret=10; preload near wrap, one valid -> instret=0.
//  5. WB_MISALIGN_TRAP_EN: LW at 32'h1002 -> err=1, addr=32'h1002;
//     then LH at 32'h2001 -> addr unchanged; clr together with new LHU at 32'h3003
//     -> err=1, addr=32'h3003.
//  6. Drop reset low mid-stream with en=1 -> all outputs 0 asynchronously, before the next
//     clk edge; after release, first valid instruction -> instret=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and load-type constants for the writeback stage.
// Optional misaligned-load trap logic is enabled by defining WB_MISALIGN_TRAP_EN.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_MEM  = 2'd2,
    WB_RSVD = 2'd3
  } wb_src_e;

  // Load funct3 encodings, shared with the decoder's load definitions.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_if.sv
// MEMWB-to-WB bundle plus the stage's forward, WBID, counter and misalign outputs.
// The misalign signals only carry state when WB_MISALIGN_TRAP_EN is defined.
interface wb_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 64
);
  logic                 instr_valid_MEMWB;
  logic [WIDTH-1:0]     ALU_out_MEMWB;
  logic [WIDTH-1:0]     pc_4_MEMWB;
  logic [WIDTH-1:0]     mem_rd_data_MEMWB;
  logic [1:0]           reg_wr_ctrl_MEMWB;
  logic [2:0]           funct3_MEMWB;
  logic [1:0]           byte_offset_MEMWB;
  logic [4:0]           rd_MEMWB;
  logic                 reg_wr_en_MEMWB;
  logic                 misalign_clr;

  logic [WIDTH-1:0]     wb_fwd_data;
  logic                 wb_fwd_en;
  logic [WIDTH-1:0]     reg_wr_data_WBID;
  logic [4:0]           rd_WBID;
  logic                 reg_wr_en_WBID;
  logic [CNT_WIDTH-1:0] instret;
  logic                 misalign_err;
  logic [WIDTH-1:0]     misalign_addr;

  modport master (
    output instr_valid_MEMWB, ALU_out_MEMWB, pc_4_MEMWB, mem_rd_data_MEMWB,
           reg_wr_ctrl_MEMWB, funct3_MEMWB, byte_offset_MEMWB, rd_MEMWB,
           reg_wr_en_MEMWB, misalign_clr,
    input  wb_fwd_data, wb_fwd_en, reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID,
           instret, misalign_err, misalign_addr
  );

  modport slave (
    input  instr_valid_MEMWB, ALU_out_MEMWB, pc_4_MEMWB, mem_rd_data_MEMWB,
           reg_wr_ctrl_MEMWB, funct3_MEMWB, byte_offset_MEMWB, rd_MEMWB,
           reg_wr_en_MEMWB, misalign_clr,
    output wb_fwd_data, wb_fwd_en, reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID,
           instret, misalign_err, misalign_addr
  );

endinterface

// File: rtl/wb_load_align.sv
// load_align: shifts the raw memory word by the byte offset, then masks and
// sign/zero-extends it according to the load type. Purely combinational.
module load_align
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [1:0]       i_offset,
  input  logic [2:0]       i_funct3,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_shifted;

  // Logical shift: bytes past the top of the word come in as zero, never wrap.
  assign w_shifted = i_word >> {i_offset, 3'b000};

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{(WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_data = {{(WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_data = {{(WIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_LHU:  o_data = {{(WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: selects the register write value, registers the WBID write port,
// counts retired instructions. Define WB_MISALIGN_TRAP_EN for the sticky misalign trap.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  wb_if.slave  io_wb
);

  localparam logic [CNT_WIDTH-1:0] INSTRET_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     w_load_data;
  logic [WIDTH-1:0]     w_wr_data;
  logic                 w_wr_en;

  logic [WIDTH-1:0]     r_wr_data;
  logic [4:0]           r_rd;
  logic                 r_wr_en;
  logic [CNT_WIDTH-1:0] r_instret;

  load_align #(.WIDTH(WIDTH)) u_load_align (
    .i_word   (io_wb.mem_rd_data_MEMWB),
    .i_offset (io_wb.byte_offset_MEMWB),
    .i_funct3 (io_wb.funct3_MEMWB),
    .o_data   (w_load_data)
  );

  always_comb begin
    w_wr_data = '0;
    case (wb_src_e'(io_wb.reg_wr_ctrl_MEMWB))
      WB_ALU:  w_wr_data = io_wb.ALU_out_MEMWB;
      WB_PC4:  w_wr_data = io_wb.pc_4_MEMWB;
      WB_MEM:  w_wr_data = w_load_data;
      default: w_wr_data = '0;
    endcase
  end

  // Writes to x0 and bubbles never reach the register file.
  assign w_wr_en = io_wb.reg_wr_en_MEMWB & io_wb.instr_valid_MEMWB &
                   (io_wb.rd_MEMWB != 5'd0);

  assign io_wb.wb_fwd_data = w_wr_data;
  assign io_wb.wb_fwd_en   = w_wr_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_data <= '0;
      r_rd      <= '0;
      r_wr_en   <= 1'b0;
      r_instret <= '0;
    end else begin
      r_wr_data <= w_wr_data;
      r_rd      <= io_wb.rd_MEMWB;
      r_wr_en   <= w_wr_en;
      if (io_wb.instr_valid_MEMWB) begin
        r_instret <= r_instret + INSTRET_ONE;
      end
    end
  end

  assign io_wb.reg_wr_data_WBID = r_wr_data;
  assign io_wb.rd_WBID          = r_rd;
  assign io_wb.reg_wr_en_WBID   = r_wr_en;
  assign io_wb.instret          = r_instret;

`ifdef WB_MISALIGN_TRAP_EN
  logic             w_misalign;
  logic             r_misalign_err;
  logic [WIDTH-1:0] r_misalign_addr;

  always_comb begin
    w_misalign = 1'b0;
    if (io_wb.instr_valid_MEMWB && (io_wb.reg_wr_ctrl_MEMWB == WB_MEM)) begin
      case (io_wb.funct3_MEMWB)
        F3_LH, F3_LHU: w_misalign = io_wb.byte_offset_MEMWB[0];
        F3_LW:         w_misalign = (io_wb.byte_offset_MEMWB != 2'd0);
        default:       w_misalign = 1'b0;
      endcase
    end
  end

  // A clear in the same cycle as a new event re-arms capture, so the new address wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign_err  <= 1'b0;
      r_misalign_addr <= '0;
    end else if (w_misalign && (!r_misalign_err || io_wb.misalign_clr)) begin
      r_misalign_err  <= 1'b1;
      r_misalign_addr <= io_wb.ALU_out_MEMWB;
    end else if (io_wb.misalign_clr) begin
      r_misalign_err  <= 1'b0;
    end
  end

  assign io_wb.misalign_err  = r_misalign_err;
  assign io_wb.misalign_addr = r_misalign_addr;
`else
  logic w_unused_clr;

  assign w_unused_clr        = io_wb.misalign_clr;
  assign io_wb.misalign_err  = 1'b0;
  assign io_wb.misalign_addr = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: byte-level reference model, randomized and
// directed stimulus, asynchronous reset checks. Uses an 8-bit instret to reach wrap.
module tb_writeback_stage;

  localparam int W  = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [4:0]    rd;
    logic          en;
    logic [W-1:0]  fwdData;
    logic          fwdEn;
    logic [CW-1:0] instret;
    logic          err;
    logic [W-1:0]  addr;
  } exp_t;

  logic clk;
  logic rstN;
  int   testsRun;
  int   failCount;
  bit   monActive;
  exp_t scoreQ[$];

  logic [CW-1:0] refCnt;
  logic          refErr;
  logic [W-1:0]  refAddr;

  wb_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  writeback_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .io_wb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Reference load: pick bytes starting at the offset, missing bytes read as zero.
  function automatic logic [W-1:0] refLoad(input logic [W-1:0] word, input int off,
                                           input logic [2:0] f3);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) begin
      b[k] = (off + k < 4) ? word[8*(off+k) +: 8] : 8'h00;
    end
    case (f3)
      3'd0:    return {{24{b[0][7]}}, b[0]};
      3'd1:    return {{16{b[1][7]}}, b[1], b[0]};
      3'd4:    return {24'h0, b[0]};
      3'd5:    return {16'h0, b[1], b[0]};
      default: return word;
    endcase
  endfunction

  task automatic applyStimulus(input logic valid, input logic [W-1:0] alu, input logic [W-1:0] pc4,
                               input logic [W-1:0] mem, input logic [1:0] ctrl,
                               input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                               input logic en, input logic clr);
    exp_t e;
    logic [W-1:0] val;
    logic mis;
    @(negedge clk);
    #1;
    bus.instr_valid_MEMWB = valid;
    bus.ALU_out_MEMWB     = alu;
    bus.pc_4_MEMWB        = pc4;
    bus.mem_rd_data_MEMWB = mem;
    bus.reg_wr_ctrl_MEMWB = ctrl;
    bus.funct3_MEMWB      = f3;
    bus.byte_offset_MEMWB = off;
    bus.rd_MEMWB          = rd;
    bus.reg_wr_en_MEMWB   = en;
    bus.misalign_clr      = clr;
    case (ctrl)
      2'd0:    val = alu;
      2'd1:    val = pc4;
      2'd2:    val = refLoad(mem, int'(off), f3);
      default: val = '0;
    endcase
    e.data    = val;
    e.fwdData = val;
    e.rd      = rd;
    e.en      = en && valid && (rd != 5'd0);
    e.fwdEn   = e.en;
    if (valid) refCnt = refCnt + 8'd1;
    e.instret = refCnt;
`ifdef WB_MISALIGN_TRAP_EN
    mis = valid && (ctrl == 2'd2) &&
          ((((f3 == 3'd1) || (f3 == 3'd5)) && off[0]) || ((f3 == 3'd2) && (off != 2'd0)));
    if (mis && (!refErr || clr)) begin
      refErr  = 1'b1;
      refAddr = alu;
    end else if (clr) begin
      refErr = 1'b0;
    end
`else
    mis = 1'b0;
`endif
    e.err  = refErr;
    e.addr = refAddr;
    scoreQ.push_back(e);
  endtask

  task automatic randomStim(input logic forceValid);
    logic v;
    v = forceValid ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    applyStimulus(v, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
  endtask

  task automatic driveBubble();
    bus.instr_valid_MEMWB = 1'b0;
    bus.reg_wr_en_MEMWB   = 1'b0;
    bus.misalign_clr      = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_data"}, 64'(bus.reg_wr_data_WBID), 64'h0);
    checkOutput({tag, "_rd"}, 64'(bus.rd_WBID), 64'h0);
    checkOutput({tag, "_en"}, 64'(bus.reg_wr_en_WBID), 64'h0);
    checkOutput({tag, "_instret"}, 64'(bus.instret), 64'h0);
    checkOutput({tag, "_err"}, 64'(bus.misalign_err), 64'h0);
    checkOutput({tag, "_addr"}, 64'(bus.misalign_addr), 64'h0);
  endtask

  // Monitor: every negedge the DUT presents a WBID result for the previous issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (monActive && (scoreQ.size() > 0)) begin
        e = scoreQ.pop_front();
        checkOutput("wbid_data", 64'(bus.reg_wr_data_WBID), 64'(e.data));
        checkOutput("wbid_rd", 64'(bus.rd_WBID), 64'(e.rd));
        checkOutput("wbid_en", 64'(bus.reg_wr_en_WBID), 64'(e.en));
        checkOutput("fwd_data", 64'(bus.wb_fwd_data), 64'(e.fwdData));
        checkOutput("fwd_en", 64'(bus.wb_fwd_en), 64'(e.fwdEn));
        checkOutput("instret", 64'(bus.instret), 64'(e.instret));
        checkOutput("misalign_err", 64'(bus.misalign_err), 64'(e.err));
        checkOutput("misalign_addr", 64'(bus.misalign_addr), 64'(e.addr));
      end
    end
  end

  initial begin
    int guard;
    testsRun  = 0;
    failCount = 0;
    monActive = 1'b0;
    refCnt    = '0;
    refErr    = 1'b0;
    refAddr   = '0;
    bus.ALU_out_MEMWB     = '0;
    bus.pc_4_MEMWB        = '0;
    bus.mem_rd_data_MEMWB = '0;
    bus.reg_wr_ctrl_MEMWB = '0;
    bus.funct3_MEMWB      = '0;
    bus.byte_offset_MEMWB = '0;
    bus.rd_MEMWB          = '0;
    driveBubble();
    rstN = 1'b1;
    #2 rstN = 1'b0;
    #1 checkResetState("reset");
    repeat (2) @(negedge clk);
    #3 rstN = 1'b1;
    monActive = 1'b1;

    // Counter: 10 retired, 3 bubbles.
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'(i), 32'h4, 32'h0, 2'd0, 3'd2, 2'd0, 5'd1, 1, 0);
    for (int i = 0; i < 3; i++)  applyStimulus(0, 32'h0, 32'h4, 32'h0, 2'd0, 3'd2, 2'd0, 5'd1, 1, 0);

    // Load alignment corner cases.
    applyStimulus(1, 32'h103, 32'h8, 32'h80FF_7F01, 2'd2, 3'd0, 2'd3, 5'd7, 1, 0);
    applyStimulus(1, 32'h103, 32'h8, 32'h80FF_7F01, 2'd2, 3'd4, 2'd3, 5'd7, 1, 0);
    applyStimulus(1, 32'h102, 32'h8, 32'h8001_1234, 2'd2, 3'd1, 2'd2, 5'd8, 1, 0);
    applyStimulus(1, 32'h102, 32'h8, 32'h8001_1234, 2'd2, 3'd5, 2'd2, 5'd8, 1, 0);
    applyStimulus(1, 32'h100, 32'h8, 32'h8001_1234, 2'd2, 3'd2, 2'd0, 5'd8, 1, 0);
    applyStimulus(1, 32'h103, 32'h8, 32'hA5C3_0000, 2'd2, 3'd5, 2'd3, 5'd9, 1, 0);
    applyStimulus(1, 32'hDEAD_BEEF, 32'h8, 32'h0, 2'd3, 3'd2, 2'd0, 5'd9, 1, 0);

    // PC+4 writeback, then the same targeting x0.
    applyStimulus(1, 32'h55, 32'h104, 32'h0, 2'd1, 3'd2, 2'd0, 5'd5, 1, 0);
    applyStimulus(1, 32'h55, 32'h104, 32'h0, 2'd1, 3'd2, 2'd0, 5'd0, 1, 0);

    // Misalign sticky flag: capture, hold, clear-with-set.
    applyStimulus(0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 2'd0, 5'd0, 0, 1);
    applyStimulus(1, 32'h1002, 32'h8, 32'h1122_3344, 2'd2, 3'd2, 2'd2, 5'd3, 1, 0);
    applyStimulus(1, 32'h2001, 32'h8, 32'h1122_3344, 2'd2, 3'd1, 2'd1, 5'd3, 1, 0);
    applyStimulus(1, 32'h3003, 32'h8, 32'h1122_3344, 2'd2, 3'd5, 2'd3, 5'd3, 1, 1);
    applyStimulus(0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 2'd0, 5'd0, 0, 1);

    for (int i = 0; i < 150; i++) randomStim(0);

    // Run up to the counter's all-ones value, then retire one more to wrap.
    guard = 0;
    while ((refCnt != 8'hFF) && (guard < 400)) begin
      randomStim(1);
      guard++;
    end
    randomStim(1);

    // Asynchronous reset between edges with a live write in flight.
    applyStimulus(1, 32'h77, 32'h8, 32'h0, 2'd0, 3'd2, 2'd0, 5'd9, 1, 0);
    @(posedge clk);
    #3;
    monActive = 1'b0;
    rstN = 1'b0;
    scoreQ.delete();
    #1 checkResetState("midreset");
    refCnt  = '0;
    refErr  = 1'b0;
    refAddr = '0;
    driveBubble();
    repeat (2) @(negedge clk);
    #3 rstN = 1'b1;
    monActive = 1'b1;
    applyStimulus(1, 32'h99, 32'h8, 32'h0, 2'd0, 3'd2, 2'd0, 5'd4, 1, 0);
    for (int i = 0; i < 20; i++) randomStim(0);

    guard = 0;
    while ((scoreQ.size() > 0) && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    #2;
    checkOutput("drain_pending", 64'(scoreQ.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
